// File: rtl/add_three_sgn_arb_if.sv
// ============================================================================
// add_three_sgn_arb_if : requester operand ports and result response port
// Rev 1.0
// ============================================================================
`default_nettype none

interface add_three_sgn_arb_if #(
  parameter int BW   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*BW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ*BW-1:0] req_c;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BW:0]        rsp_sum;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );
endinterface

`default_nettype wire

// File: rtl/add_three_sgn_arb.sv
// ============================================================================
// add_three_sgn_arb : round-robin shared registered three-operand signed adder
// Rev 1.0
// ============================================================================
`default_nettype none

module add_three_sgn_arb #(
  parameter int BW   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  add_three_sgn_arb_if.slave  bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [BW:0]    r_sum;
  logic [IDW-1:0] r_id;
  logic           r_ovf;

  logic [NREQ-1:0] w_hi_mask;
  logic [NREQ-1:0] w_masked;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_any;
  logic            w_can_accept;
  logic            w_xfer;
  logic [BW-1:0]   w_a;
  logic [BW-1:0]   w_b;
  logic [BW-1:0]   w_c;
  logic [BW+1:0]   w_sum_x;
  logic [IDW-1:0]  w_ptr_nxt;

  // Requesters at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi_mask[i] = (IDW'(i) >= r_ptr);
    end
  end

  assign w_masked = bus.req_valid & w_hi_mask;

  always_comb begin
    w_gnt_id = '0;
    w_any    = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_gnt_id = IDW'(i);
        w_any    = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_gnt_id = IDW'(i);
      end
    end
  end

  assign w_gnt = w_any ? (NREQ'(1) << w_gnt_id) : '0;

  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a = bus.req_a[i*BW +: BW];
        w_b = bus.req_b[i*BW +: BW];
        w_c = bus.req_c[i*BW +: BW];
      end
    end
  end

  // Reset gates acceptance so no requester sees ready while rst is high.
  assign w_can_accept  = ~rst & ((r_state == S_EMPTY) | bus.rsp_ready);
  assign bus.req_ready = w_gnt & {NREQ{w_can_accept}};
  assign w_xfer        = |bus.req_ready;

  // Two guard bits hold the exact sum; overflow when the top two disagree.
  assign w_sum_x = {{2{w_a[BW-1]}}, w_a}
                 + {{2{w_b[BW-1]}}, w_b}
                 + {{2{w_c[BW-1]}}, w_c};

  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_xfer) begin
      r_state <= S_FULL;
      r_ptr   <= w_ptr_nxt;
      r_sum   <= w_sum_x[BW:0];
      r_id    <= w_gnt_id;
      r_ovf   <= w_sum_x[BW+1] ^ w_sum_x[BW];
    end else if ((r_state == S_FULL) && bus.rsp_ready) begin
      r_state <= S_EMPTY;
    end
  end

  assign bus.rsp_valid = (r_state == S_FULL);
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_add_three_sgn_arb.sv
// ============================================================================
// tb_add_three_sgn_arb : scoreboard bench for the shared signed adder arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_three_sgn_arb;

  localparam int BW   = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [BW:0]    sum;
    logic [IDW-1:0] id;
    logic           ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_three_sgn_arb_if #(.BW(BW), .NREQ(NREQ), .IDW(IDW)) bus ();

  add_three_sgn_arb #(.BW(BW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int              n_checks = 0;
  int              n_pass   = 0;
  rsp_t            q[$];
  bit              m_full;
  int              m_ptr;
  logic [NREQ-1:0] m_acc;

  function automatic void chk(string nm, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // Reference arbitration: linear scan from the pointer with wrap-around.
  function automatic int model_grant(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [BW-1:0] rnd_op();
    case ($urandom % 5)
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'hab;
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_acc  = '0;
    q.delete();
  endtask

  // Predicts req_ready and the resulting transfer for the upcoming edge.
  initial begin : checker_proc
    bit              can;
    int              g;
    int              ex;
    logic [NREQ-1:0] expr;
    rsp_t            e;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("req_ready_in_reset", longint'(bus.req_ready), 0);
        model_reset();
      end else begin
        can  = !m_full || bus.rsp_ready;
        g    = model_grant(bus.req_valid, m_ptr);
        expr = (can && g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", longint'(bus.req_ready), longint'(expr));
        m_acc = expr;
        if (expr != '0) begin
          ex = int'($signed(bus.req_a[g*BW +: BW]))
             + int'($signed(bus.req_b[g*BW +: BW]))
             + int'($signed(bus.req_c[g*BW +: BW]));
          e.sum = ex[BW:0];
          e.id  = IDW'(g);
          e.ovf = (ex < -(1 << BW)) || (ex > (1 << BW) - 1);
          q.push_back(e);
          m_full = 1'b1;
          m_ptr  = (g + 1) % NREQ;
        end else if (m_full && bus.rsp_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  initial begin : monitor_proc
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rsp_valid", longint'(bus.rsp_valid), longint'(m_full));
        if (bus.rsp_valid && m_full && q.size() > 0) begin
          e = q[0];
          chk("rsp_sum", longint'(bus.rsp_sum), longint'(e.sum));
          chk("rsp_id",  longint'(bus.rsp_id),  longint'(e.id));
          chk("rsp_ovf", longint'(bus.rsp_ovf), longint'(e.ovf));
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle; requesters that were just accepted withdraw their request.
  task automatic step();
    cyc();
    bus.req_valid = bus.req_valid & ~m_acc;
  endtask

  task automatic set_ops(int i, logic [BW-1:0] a, logic [BW-1:0] b, logic [BW-1:0] c);
    bus.req_a[i*BW +: BW] = a;
    bus.req_b[i*BW +: BW] = b;
    bus.req_c[i*BW +: BW] = c;
  endtask

  task automatic send(int i, logic [BW-1:0] a, logic [BW-1:0] b, logic [BW-1:0] c);
    set_ops(i, a, b, c);
    bus.req_valid = NREQ'(1) << i;
    step();
  endtask

  initial begin : stim
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b1;
    #1 rst = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, BW'(i + 1), BW'(2 * i), BW'(3));
    #7;
    chk("reset_rsp_valid", longint'(bus.rsp_valid), 0);
    chk("reset_rsp_sum",   longint'(bus.rsp_sum),   0);
    chk("reset_rsp_id",    longint'(bus.rsp_id),    0);
    chk("reset_rsp_ovf",   longint'(bus.rsp_ovf),   0);
    chk("reset_req_ready", longint'(bus.req_ready), 0);
    cyc();
    rst = 1'b0;
    step();
    bus.req_valid = '0;
    step();

    send(1, 8'd100, 8'd50, 8'hec);
    send(0, 8'h80, 8'h80, 8'h80);
    send(2, 8'h7f, 8'h7f, 8'h7f);
    send(3, 8'h7f, 8'h7f, 8'h00);
    send(1, 8'hab, 8'hab, 8'hab);
    send(3, 8'd1, 8'd1, 8'd1);
    bus.req_valid = '0;
    step();

    for (int i = 0; i < NREQ; i++) set_ops(i, BW'(10 * i + 5), BW'(7 - i), BW'(20 * i));
    bus.req_valid = 4'b1111;
    repeat (6) cyc();
    bus.req_valid = '0;
    step();

    bus.req_valid = 4'b1111;
    cyc();
    bus.rsp_ready = 1'b0;
    repeat (3) cyc();
    bus.rsp_ready = 1'b1;
    repeat (2) cyc();
    bus.req_valid = '0;
    step();

    send(2, 8'd3, 8'd4, 8'd5);
    bus.req_valid = '0;
    repeat (5) step();
    set_ops(0, 8'd9, 8'hf0, 8'd2);
    set_ops(3, 8'h81, 8'd1, 8'h90);
    bus.req_valid = 4'b1001;
    repeat (3) step();

    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    cyc();
    bus.req_valid = 4'b1111;
    cyc();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("midreset_rsp_valid", longint'(bus.rsp_valid), 0);
    chk("midreset_req_ready", longint'(bus.req_ready), 0);
    cyc();
    cyc();
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    step();
    bus.req_valid = '0;
    step();

    for (int n = 0; n < 400; n++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || m_acc[i]) begin
          bus.req_valid[i] = 1'($urandom % 2);
          set_ops(i, rnd_op(), rnd_op(), rnd_op());
        end
      end
      bus.rsp_ready = 1'(($urandom % 4) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_three_sgn_arb.md
# add_three_sgn_arb

Round-robin arbiter and scheduler that shares one registered three-operand signed adder between `NREQ` requesters. Each requester presents an (a, b, c) operand triple with a valid/ready handshake. The block grants one requester per cycle and registers the sign-extended sum together with the requester id and an overflow flag. It returns the result on a single valid/ready response port that supports backpressure. It sits between operand producers and any consumer of three-way signed sums.

## Interface
- `BW`, default 8: operand width. Operands are signed two's complement.
- `NREQ`, default 4: number of requesters, minimum 2.
- `IDW`, default `$clog2(NREQ)`: width of the requester id.
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester operand valid.
- `req_ready`, output, NREQ: per-requester accept. At most one bit is high in any cycle.
- `req_a`, input, NREQ*BW: operand a. Requester i occupies bits [i*BW +: BW].
- `req_b`, input, NREQ*BW: operand b, same packing as `req_a`.
- `req_c`, input, NREQ*BW: operand c, same packing as `req_a`.
- `rsp_valid`, output, 1: result register holds a result.
- `rsp_ready`, input, 1: consumer accepts the result.
- `rsp_sum`, output, BW+1: signed sum a+b+c, computed modulo 2^(BW+1).
- `rsp_id`, output, IDW: index of the requester that produced `rsp_sum`.
- `rsp_ovf`, output, 1: high when the exact sum is outside the signed (BW+1)-bit range.

## Operation
- **Result register:** a single entry with two states.
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- **Accept condition:** `can_accept` = EMPTY, or (FULL and `rsp_ready`). A full register that drains in the same cycle accepts a new triple in that cycle.
- **Grant:** computed combinationally from `req_valid` and the priority pointer `ptr`.
  - The granted requester is the first i with `req_valid[i]`=1, scanning ptr, ptr+1, … , NREQ-1, 0, … , ptr-1.
  - `req_ready[i]` = grant[i] & `can_accept`.
  - `req_ready` may depend on `req_valid`. `req_valid` must not depend on `req_ready`.
- **Transfer:** a transfer on requester i occurs when `req_valid[i]` & `req_ready[i]`. On a transfer:
  - `rsp_sum` ← sext(a)+sext(b)+sext(c), with each operand sign-extended to BW+1 bits and the result truncated to BW+1 bits (wrap-around).
  - `rsp_ovf` ← 1 if the exact sum is below -2^BW or above 2^BW-1. The exact sum needs BW+2 bits for this check.
  - `rsp_id` ← i.
  - The register moves to FULL.
  - `ptr` ← (i+1) mod NREQ.
- **Drain without refill:** FULL with `rsp_ready`=1 and no transfer → EMPTY. `rsp_sum`, `rsp_id` and `rsp_ovf` keep their last values.
- **Backpressure:** FULL with `rsp_ready`=0 → all `req_ready`=0. `rsp_sum`, `rsp_id` and `rsp_ovf` are held stable.
- **Idle:** `ptr` does not change in any cycle without a transfer.
- **Requester obligation:** a requester holds `req_valid` and its operands stable until it is accepted. The block does not check this.
- **Fairness:** a continuously valid requester is granted within NREQ transfers.

## Timing
- **Reset (asynchronous, while `rst`=1):**
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `rsp_ovf`=0, `ptr`=0.
  - `req_ready`=0 throughout reset.
- **Reset mid-operation:** an in-flight result is discarded. `rsp_valid` falls asynchronously and no response is produced for it.
- **Latency:** a transfer at cycle N gives `rsp_valid`=1 with the result from cycle N+1.
- **Throughput:** one result per cycle while `rsp_ready`=1 and some `req_valid`=1.
- **Path:** `rsp_ready` → `req_ready` is combinational. There is no other combinational input-to-output path except `req_valid` → `req_ready`.

## Test plan
- **Reset mid-operation:**
  - Stimulus: assert `rst` between clock edges while FULL.
  - Response: `rsp_valid` falls immediately and all `req_ready`=0.
  - After release, with `req_valid`=4'b1111: grant goes to requester 0.
- **Single request, no overflow:** requester 1 only, a=100, b=50, c=-20, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_sum`=130, `rsp_id`=1, `rsp_ovf`=0.
- **Overflow and wrap-around (BW=8):**
  - a=b=c=-128 → `rsp_sum`=128, `rsp_ovf`=1.
  - a=b=c=127 → `rsp_sum`=-131, `rsp_ovf`=1.
  - a=127, b=127, c=0 → `rsp_sum`=254, `rsp_ovf`=0.
  - a=b=c=-85 → `rsp_sum`=-255, `rsp_ovf`=0.
- **Round-robin under full load:**
  - Stimulus: `req_valid`=4'b1111 held, `rsp_ready`=1, operands distinct per requester.
  - Response: `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles, each with the matching sum.
- **Backpressure:**
  - Stimulus: while FULL, drop `rsp_ready` for 3 cycles with all `req_valid` high.
  - Response: `rsp_sum`, `rsp_id` and `rsp_ovf` unchanged and `req_ready`=0 for all 3 cycles.
  - When `rsp_ready` rises: same-cycle accept of the next requester, and the new result appears the following cycle with no bubble.
- **Pointer update:**
  - Stimulus: accept requester 2 alone, then present `req_valid`=4'b1001.
  - Response: requester 3 is granted first, then requester 0.
  - With no transfer for 5 idle cycles, `ptr` remains 3.
